// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM burst port scheduler.
//   SDRAM_ADDR_W  : default SDRAM word address width
//   SDRAM_BURST   : default burst length in words
//   sched_state_e : scheduler FSM states
//   chan_e        : channel identifier, used for round-robin bookkeeping
package sdram_pkg;

  localparam int         SDRAM_ADDR_W = 24;
  localparam logic [9:0] SDRAM_BURST  = 10'd256;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARB      = 3'd1,
    ST_WR_REQ   = 3'd2,
    ST_WR_BURST = 3'd3,
    ST_RD_REQ   = 3'd4,
    ST_RD_BURST = 3'd5
  } sched_state_e;

  typedef enum logic {
    CH_WR = 1'b0,
    CH_RD = 1'b1
  } chan_e;

endpackage

// File: rtl/sdram_addr_ptr.sv
// Per-channel burst address pointer.
// Holds the start address of the channel's next burst. Reloads the base while
// the scheduler is idle, advances by one burst at each burst end and wraps to
// the base when the following burst would run past the region end.
// Ports:
//   clk_i, srst_i : clock, synchronous active-high reset
//   load_i        : scheduler idle, force pointer to base
//   active_i      : this channel is in its REQ or BURST phase
//   done_i        : this channel's burst ends this cycle
//   flush_i       : return pointer to base (deferred while active)
//   base_i, end_i : inclusive word-address region
//   ptr_o         : current burst start address
//   wrap_o        : one-cycle pulse when the increment wraps to base
module sdram_addr_ptr
  import sdram_pkg::*;
#(
  parameter int         ADDR_W = SDRAM_ADDR_W,
  parameter logic [9:0] BURST  = SDRAM_BURST
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              load_i,
  input  logic              active_i,
  input  logic              done_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] end_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              wrap_o
);

  localparam logic [9:0] BURST_M1 = BURST - 10'd1;

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              pend_q, pend_d;
  logic              wrap_q, wrap_d;

  // Extra headroom bits so the end-of-next-burst comparison cannot overflow.
  logic [ADDR_W:0]   nxt;
  logic [ADDR_W+1:0] nxt_last;
  logic              over;

  assign nxt      = {1'b0, ptr_q} + {{(ADDR_W-9){1'b0}}, BURST};
  assign nxt_last = {1'b0, nxt} + {{(ADDR_W-8){1'b0}}, BURST_M1};
  assign over     = nxt_last > {2'b00, end_i};

  always_comb begin
    ptr_d  = ptr_q;
    pend_d = pend_q;
    wrap_d = 1'b0;
    if (load_i) begin
      ptr_d  = base_i;
      pend_d = 1'b0;
    end else if (done_i) begin
      // A pending or coincident flush replaces the increment and never wraps.
      pend_d = 1'b0;
      if (pend_q || flush_i) begin
        ptr_d = base_i;
      end else if (over) begin
        ptr_d  = base_i;
        wrap_d = 1'b1;
      end else begin
        ptr_d = nxt[ADDR_W-1:0];
      end
    end else if (flush_i) begin
      // The address must stay stable while the controller uses it.
      if (active_i) begin
        pend_d = 1'b1;
      end else begin
        ptr_d = base_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ptr_q  <= '0;
      pend_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      pend_q <= pend_d;
      wrap_q <= wrap_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/sdram_port_sched.sv
// Round-robin burst scheduler between the write/read FIFOs and the SDRAM
// controller user ports. Grants one burst at a time, drives request, start
// address and burst length, and advances per-channel pointers.
// Ports:
//   sys_clk, sys_rst           : clock, synchronous active-high reset
//   init_end                   : controller initialisation complete
//   wr_base/wr_end, rd_base/rd_end : inclusive address regions
//   wr_fifo_used, rd_fifo_used : FIFO fill levels
//   rd_enable                  : consumer wants read traffic
//   wr_flush, rd_flush         : return channel pointer to base
//   sdram_wr_ack, sdram_rd_ack : controller data-phase strobes
//   sdram_wr_req, sdram_rd_req : burst requests (registered)
//   sdram_wr_addr, sdram_rd_addr : burst start addresses (registered)
//   wr_burst_len, rd_burst_len : constant burst length
//   busy                       : a request or burst is in progress
//   wr_wrap, rd_wrap           : pointer wrapped to base
module sdram_port_sched
  import sdram_pkg::*;
#(
  parameter int         ADDR_W   = SDRAM_ADDR_W,
  parameter int         LVL_W    = 10,
  parameter logic [9:0] BURST    = SDRAM_BURST,
  parameter int         RD_DEPTH = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [ADDR_W-1:0] wr_end,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] rd_end,
  input  logic [LVL_W-1:0]  wr_fifo_used,
  input  logic [LVL_W-1:0]  rd_fifo_used,
  input  logic              rd_enable,
  input  logic              wr_flush,
  input  logic              rd_flush,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  output logic [9:0]        wr_burst_len,
  output logic [9:0]        rd_burst_len,
  output logic              busy,
  output logic              wr_wrap,
  output logic              rd_wrap
);

  sched_state_e state_q, state_d;
  chan_e        last_q, last_d;
  logic         wr_req_q, rd_req_q, busy_q;
  logic         wr_ack_q, rd_ack_q;

  logic         wr_elig, rd_elig;
  logic         wr_done, rd_done;

  logic [ADDR_W-1:0] base_a [2];
  logic [ADDR_W-1:0] end_a  [2];
  logic [ADDR_W-1:0] ptr_a  [2];
  logic [1:0]        active, done, flush, wrap;
  logic              load;

  assign wr_elig = 32'(wr_fifo_used) >= 32'(BURST);
  assign rd_elig = rd_enable && ((32'(rd_fifo_used) + 32'(BURST)) <= 32'(RD_DEPTH));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wr_done = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init_end) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!init_end) begin
          state_d = ST_IDLE;
        end else if (wr_elig && (!rd_elig || last_q == CH_RD)) begin
          state_d = ST_WR_REQ;
          last_d  = CH_WR;
        end else if (rd_elig) begin
          state_d = ST_RD_REQ;
          last_d  = CH_RD;
        end
      end
      ST_WR_REQ: begin
        if (sdram_wr_ack) state_d = ST_WR_BURST;
      end
      ST_WR_BURST: begin
        // Burst ends on the falling edge of the data-phase strobe.
        if (wr_ack_q && !sdram_wr_ack) begin
          wr_done = 1'b1;
          state_d = init_end ? ST_ARB : ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (sdram_rd_ack) state_d = ST_RD_BURST;
      end
      ST_RD_BURST: begin
        if (rd_ack_q && !sdram_rd_ack) begin
          rd_done = 1'b1;
          state_d = init_end ? ST_ARB : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // register and need no extra pipeline stage.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      last_q   <= CH_RD;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      busy_q   <= 1'b0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      wr_req_q <= (state_d == ST_WR_REQ);
      rd_req_q <= (state_d == ST_RD_REQ);
      busy_q   <= (state_d != ST_IDLE) && (state_d != ST_ARB);
      wr_ack_q <= sdram_wr_ack;
      rd_ack_q <= sdram_rd_ack;
    end
  end

  // Channel 0 is write, channel 1 is read.
  assign load      = (state_q == ST_IDLE);
  assign active[0] = (state_q == ST_WR_REQ) || (state_q == ST_WR_BURST);
  assign active[1] = (state_q == ST_RD_REQ) || (state_q == ST_RD_BURST);
  assign done      = {rd_done, wr_done};
  assign flush     = {rd_flush, wr_flush};
  assign base_a[0] = wr_base;
  assign base_a[1] = rd_base;
  assign end_a[0]  = wr_end;
  assign end_a[1]  = rd_end;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
      sdram_addr_ptr #(
        .ADDR_W (ADDR_W),
        .BURST  (BURST)
      ) u_ptr (
        .clk_i    (sys_clk),
        .srst_i   (sys_rst),
        .load_i   (load),
        .active_i (active[gi]),
        .done_i   (done[gi]),
        .flush_i  (flush[gi]),
        .base_i   (base_a[gi]),
        .end_i    (end_a[gi]),
        .ptr_o    (ptr_a[gi]),
        .wrap_o   (wrap[gi])
      );
    end
  endgenerate

  assign sdram_wr_req  = wr_req_q;
  assign sdram_rd_req  = rd_req_q;
  assign sdram_wr_addr = ptr_a[0];
  assign sdram_rd_addr = ptr_a[1];
  assign wr_burst_len  = BURST;
  assign rd_burst_len  = BURST;
  assign busy          = busy_q;
  assign wr_wrap       = wrap[0];
  assign rd_wrap       = wrap[1];

endmodule

// File: tb/tb_sdram_port_sched.sv
module tb_sdram_port_sched;

  logic        sys_clk;
  logic        sys_rst;
  logic        init_end;
  logic [23:0] wr_base, wr_end, rd_base, rd_end;
  logic [9:0]  wr_fifo_used, rd_fifo_used;
  logic        rd_enable, wr_flush, rd_flush;
  logic        sdram_wr_ack, sdram_rd_ack;
  logic        sdram_wr_req, sdram_rd_req;
  logic [23:0] sdram_wr_addr, sdram_rd_addr;
  logic [9:0]  wr_burst_len, rd_burst_len;
  logic        busy, wr_wrap, rd_wrap;

  int n_total = 0;
  int n_pass  = 0;

  sdram_port_sched #(
    .ADDR_W   (24),
    .LVL_W    (10),
    .BURST    (10'd256),
    .RD_DEPTH (1024)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .init_end      (init_end),
    .wr_base       (wr_base),
    .wr_end        (wr_end),
    .rd_base       (rd_base),
    .rd_end        (rd_end),
    .wr_fifo_used  (wr_fifo_used),
    .rd_fifo_used  (rd_fifo_used),
    .rd_enable     (rd_enable),
    .wr_flush      (wr_flush),
    .rd_flush      (rd_flush),
    .sdram_wr_ack  (sdram_wr_ack),
    .sdram_rd_ack  (sdram_rd_ack),
    .sdram_wr_req  (sdram_wr_req),
    .sdram_rd_req  (sdram_rd_req),
    .sdram_wr_addr (sdram_wr_addr),
    .sdram_rd_addr (sdram_rd_addr),
    .wr_burst_len  (wr_burst_len),
    .rd_burst_len  (rd_burst_len),
    .busy          (busy),
    .wr_wrap       (wr_wrap),
    .rd_wrap       (rd_wrap)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // The two requests must never be high together.
  always @(negedge sys_clk) begin
    if (!sys_rst && sdram_wr_req && sdram_rd_req)
      check("mutex_req", 32'({sdram_wr_req, sdram_rd_req}), 32'h1);
  end

  task automatic do_reset(input logic [23:0] wb, input logic [23:0] we,
                          input logic [23:0] rb, input logic [23:0] re);
    sys_rst = 1'b1; init_end = 1'b0;
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
    wr_flush = 1'b0; rd_flush = 1'b0;
    wr_fifo_used = '0; rd_fifo_used = '0; rd_enable = 1'b0;
    wr_base = wb; wr_end = we; rd_base = rb; rd_end = re;
    step(); step();
    sys_rst = 1'b0; init_end = 1'b1;
    step();  // IDLE -> ARB
  endtask

  // From ARB: apply levels, expect a grant (or none), then run the handshake.
  task automatic grant(input logic [9:0] wu, input logic [9:0] ru, input logic ren,
                       input logic ew, input logic er, input logic [23:0] ea,
                       input logic ewrap, input logic fl_end, input string nm);
    logic [23:0] a;
    wr_fifo_used = wu; rd_fifo_used = ru; rd_enable = ren;
    step();
    check({nm, "_wreq"}, 32'(sdram_wr_req), 32'(ew));
    check({nm, "_rreq"}, 32'(sdram_rd_req), 32'(er));
    if (ew || er) begin
      a = ew ? sdram_wr_addr : sdram_rd_addr;
      check({nm, "_addr"}, 32'(a), 32'(ea));
      if (ew) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
      step();
      check({nm, "_reqlow"}, 32'({sdram_wr_req, sdram_rd_req}), 32'h0);
      check({nm, "_busy1"}, 32'(busy), 32'h1);
      a = ew ? sdram_wr_addr : sdram_rd_addr;
      check({nm, "_addr_hold"}, 32'(a), 32'(ea));
      sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
      if (ew) wr_flush = fl_end; else rd_flush = fl_end;
      step();
      wr_flush = 1'b0; rd_flush = 1'b0;
      check({nm, "_busy0"}, 32'(busy), 32'h0);
      check({nm, "_wrap"}, 32'(ew ? wr_wrap : rd_wrap), 32'(ewrap));
    end else begin
      check({nm, "_idle_busy"}, 32'(busy), 32'h0);
    end
  endtask

  typedef struct {
    logic [9:0]  wr_used;
    logic [9:0]  rd_used;
    logic        rd_en;
    logic        exp_w;
    logic        exp_r;
    logic [23:0] exp_addr;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // wr region 0..0xFFFF, rd region 0x1000..0x1FFF, BURST=256, RD_DEPTH=1024
    vecs[0]  = '{10'd300, 10'd0,    1'b1, 1'b1, 1'b0, 24'h000000}; // tie: write first
    vecs[1]  = '{10'd300, 10'd0,    1'b1, 1'b0, 1'b1, 24'h001000}; // tie: read
    vecs[2]  = '{10'd300, 10'd0,    1'b1, 1'b1, 1'b0, 24'h000100};
    vecs[3]  = '{10'd300, 10'd0,    1'b1, 1'b0, 1'b1, 24'h001100};
    vecs[4]  = '{10'd100, 10'd800,  1'b1, 1'b0, 1'b0, 24'h000000}; // 224 free: none
    vecs[5]  = '{10'd100, 10'd768,  1'b1, 1'b0, 1'b1, 24'h001200}; // 256 free: read
    vecs[6]  = '{10'd256, 10'd0,    1'b0, 1'b1, 1'b0, 24'h000200}; // level == BURST
    vecs[7]  = '{10'd255, 10'd0,    1'b1, 1'b0, 1'b1, 24'h001300};
    vecs[8]  = '{10'd255, 10'd769,  1'b1, 1'b0, 1'b0, 24'h000000};
    vecs[9]  = '{10'd300, 10'd0,    1'b0, 1'b1, 1'b0, 24'h000300};
    vecs[10] = '{10'd300, 10'd1023, 1'b1, 1'b1, 1'b0, 24'h000400};
    vecs[11] = '{10'd0,   10'd0,    1'b0, 1'b0, 1'b0, 24'h000000};

    // Reset values
    sys_rst = 1'b1; init_end = 1'b0;
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; wr_flush = 1'b0; rd_flush = 1'b0;
    wr_fifo_used = 10'd300; rd_fifo_used = '0; rd_enable = 1'b1;
    wr_base = 24'h000100; wr_end = 24'hFFFF; rd_base = 24'h1000; rd_end = 24'h1FFF;
    step(); step();
    check("rst_reqs",  32'({sdram_wr_req, sdram_rd_req}), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_waddr", 32'(sdram_wr_addr), 32'h0);
    check("rst_raddr", 32'(sdram_rd_addr), 32'h0);
    check("rst_wraps", 32'({wr_wrap, rd_wrap}), 32'h0);
    check("rst_wlen",  32'(wr_burst_len), 32'd256);
    check("rst_rlen",  32'(rd_burst_len), 32'd256);

    // Table: arbitration, fairness, level gating, pointer advance
    do_reset(24'h0, 24'hFFFF, 24'h1000, 24'h1FFF);
    for (int i = 0; i < 12; i++) begin
      grant(vecs[i].wr_used, vecs[i].rd_used, vecs[i].rd_en,
            vecs[i].exp_w, vecs[i].exp_r, vecs[i].exp_addr, 1'b0, 1'b0,
            $sformatf("vec%0d", i));
    end

    // Wrap inside 0x100..0x4FF
    do_reset(24'h100, 24'h4FF, 24'h0, 24'hFFFF);
    grant(10'd300, 10'd0, 1'b0, 1'b1, 1'b0, 24'h100, 1'b0, 1'b0, "wrap1");
    grant(10'd300, 10'd0, 1'b0, 1'b1, 1'b0, 24'h200, 1'b0, 1'b0, "wrap2");
    grant(10'd300, 10'd0, 1'b0, 1'b1, 1'b0, 24'h300, 1'b0, 1'b0, "wrap3");
    grant(10'd300, 10'd0, 1'b0, 1'b1, 1'b0, 24'h400, 1'b1, 1'b0, "wrap4");
    grant(10'd300, 10'd0, 1'b0, 1'b1, 1'b0, 24'h100, 1'b0, 1'b0, "wrap5");

    // Region smaller than a burst: always starts at base
    do_reset(24'h10, 24'h20, 24'h0, 24'hFFFF);
    grant(10'd300, 10'd0, 1'b0, 1'b1, 1'b0, 24'h10, 1'b1, 1'b0, "small1");
    grant(10'd300, 10'd0, 1'b0, 1'b1, 1'b0, 24'h10, 1'b1, 1'b0, "small2");

    // Read flush during RD_BURST at 0x200
    do_reset(24'h0, 24'hFFFF, 24'h0, 24'hFFFF);
    grant(10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 24'h000, 1'b0, 1'b0, "fl_a");
    grant(10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 24'h100, 1'b0, 1'b0, "fl_b");
    step();
    check("fl_req", 32'(sdram_rd_req), 32'h1);
    check("fl_addr", 32'(sdram_rd_addr), 32'h200);
    sdram_rd_ack = 1'b1;
    step();                       // RD_BURST
    rd_flush = 1'b1;
    step();                       // flush latched as pending
    rd_flush = 1'b0;
    check("fl_addr_stable", 32'(sdram_rd_addr), 32'h200);
    sdram_rd_ack = 1'b0;
    step();                       // burst end
    check("fl_nowrap", 32'(rd_wrap), 32'h0);
    check("fl_busy0", 32'(busy), 32'h0);
    grant(10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 24'h000, 1'b0, 1'b0, "fl_after");
    grant(10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 24'h100, 1'b0, 1'b1, "fl_same");
    grant(10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 24'h000, 1'b0, 1'b0, "fl_same_after");

    // Reset during WR_BURST
    do_reset(24'h0, 24'hFFFF, 24'h0, 24'hFFFF);
    wr_fifo_used = 10'd300;
    step();
    check("rmid_req", 32'(sdram_wr_req), 32'h1);
    sdram_wr_ack = 1'b1;
    step();
    check("rmid_busy1", 32'(busy), 32'h1);
    sys_rst = 1'b1;
    step();
    check("rmid_req0", 32'(sdram_wr_req), 32'h0);
    check("rmid_busy0", 32'(busy), 32'h0);
    sys_rst = 1'b0; init_end = 1'b0; sdram_wr_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rmid_noreq%0d", i), 32'({sdram_wr_req, sdram_rd_req}), 32'h0);
    end
    init_end = 1'b1;
    step();
    check("rmid_arb", 32'(sdram_wr_req), 32'h0);
    step();
    check("rmid_req_again", 32'(sdram_wr_req), 32'h1);
    check("rmid_addr", 32'(sdram_wr_addr), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
